// File: rtl/adc_scan_pkg.sv
// -----------------------------------------------------------------------------
// adc_scan_pkg
// Shared types and constants for the ADC scan controller: the scan FSM state
// encoding, the ADC wrapper CSR addresses it drives, and the sequencer command
// words.
// -----------------------------------------------------------------------------
package adc_scan_pkg;

  typedef enum logic [3:0] {
    INIT_IER,   // enable the sample IRQ once after reset
    IDLE,       // wait for a period tick
    ARM,        // start a single-cycle conversion sequence
    WAIT_IRQ,   // wait for the sample IRQ (bounded by TIMEOUT_CYCLES)
    RD_REQ,     // issue a slot read
    RD_WAIT,    // wait for the read data
    CLR_ISR,    // acknowledge the sample IRQ
    COMMIT,     // publish the shadow results
    STOP        // abort the sequencer after a timeout
  } scanState_t;

  // Sequencer CSR
  localparam logic       SEQ_CMD  = 1'b0;
  // Sample-store CSRs (slots occupy 0..63)
  localparam logic [6:0] IER_ADDR = 7'd64;
  localparam logic [6:0] ISR_ADDR = 7'd65;

  // Sequencer command words: bit0 run, bits3:1 mode
  localparam logic [31:0] CMD_RUN_SINGLE = 32'h3;
  localparam logic [31:0] CMD_STOP       = 32'h0;

endpackage

// File: rtl/adc_scan_timer.sv
// -----------------------------------------------------------------------------
// adc_scan_timer
// Scan period generator. Counts 0..period-1 while enabled and ticks on wrap.
// A period of 0 means back-to-back scanning: the tick follows the FSM idle
// state instead. A new periodTicks value is only picked up at a wrap (or while
// disabled), so a change never shortens the period in flight.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   enable       scans scheduled while high; counter held at 0 while low
//   periodTicks  requested scan period in clk cycles
//   fsmIdle      scan FSM is in IDLE
//   tick         start-scan request
//   overrunSet   a period wrap happened while the FSM was busy
// -----------------------------------------------------------------------------
module adc_scan_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] periodTicks,
  input  logic                fsmIdle,
  output logic                tick,
  output logic                overrunSet
);

  logic [PERIOD_W-1:0] count;
  logic [PERIOD_W-1:0] curPeriod;
  logic                backToBack;
  logic                wrap;

  assign backToBack = (curPeriod == '0);
  assign wrap       = enable && !backToBack && (count == curPeriod - PERIOD_W'(1));
  assign tick       = backToBack ? (enable && fsmIdle) : wrap;
  // Back-to-back mode never overruns: it only ticks when the FSM is idle.
  assign overrunSet = wrap && !fsmIdle;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      curPeriod <= '0;
    end else if (!enable || backToBack) begin
      count     <= '0;
      curPeriod <= periodTicks;
    end else if (wrap) begin
      count     <= '0;
      curPeriod <= periodTicks;
    end else begin
      count     <= count + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// -----------------------------------------------------------------------------
// adc_scan_ctrl
// Autonomous ADC scan controller. Owns the sequencer and sample-store CSR
// ports of the ADC wrapper: periodically starts a single-cycle conversion,
// waits for the sample IRQ, reads NUM_SLOTS results into a shadow buffer,
// clears the ISR and then publishes the whole scan at once into a result file
// the CPU reads through resultAddr/resultData.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   enable            schedule scans while high
//   periodTicks       scan period in clk cycles (0 = back-to-back)
//   seq*              sequencer CSR strobes/address (seqRead tied 0)
//   sample*           sample-store CSR strobes/address
//   adcWriteData      shared CSR write data
//   sampleDataIn      sample-store read data (bits 11:0 used)
//   sampleValid       read data valid
//   sampleIrq         sample-complete interrupt
//   resultAddr        CPU result index
//   resultData        result[resultAddr], one cycle latency
//   scanDone          one-cycle pulse per committed scan
//   scanCount         committed scans, wrapping
//   overrun           sticky: a period tick arrived while busy
//   timeoutErr        sticky: the IRQ wait timed out
//   clearFlags        pulse clears overrun and timeoutErr
// -----------------------------------------------------------------------------
module adc_scan_ctrl
  import adc_scan_pkg::*;
#(
  parameter int NUM_SLOTS      = 8,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int PERIOD_W       = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] periodTicks,
  output logic                seqAddress,
  output logic                seqRead,
  output logic                seqWrite,
  output logic [6:0]          sampleAddress,
  output logic                sampleRead,
  output logic                sampleWrite,
  output logic [31:0]         adcWriteData,
  input  logic [31:0]         sampleDataIn,
  input  logic                sampleValid,
  input  logic                sampleIrq,
  input  logic [5:0]          resultAddr,
  output logic [11:0]         resultData,
  output logic                scanDone,
  output logic [15:0]         scanCount,
  output logic                overrun,
  output logic                timeoutErr,
  input  logic                clearFlags
);

  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  scanState_t       state;
  logic [SW-1:0]    slot;
  logic [TW-1:0]    waitCnt;
  logic [11:0]      shadow     [NUM_SLOTS];
  logic [11:0]      resultFile [NUM_SLOTS];
  logic             tick;
  logic             overrunSet;
  logic             unusedDataBits;

  assign seqRead        = 1'b0;
  assign unusedDataBits = ^sampleDataIn[31:12];

  adc_scan_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .periodTicks (periodTicks),
    .fsmIdle     (state == IDLE),
    .tick        (tick),
    .overrunSet  (overrunSet)
  );

  // Scan FSM. Strobes default low every cycle, so each one lasts exactly one
  // cycle; address and data are registered alongside the strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= INIT_IER;
      slot          <= '0;
      waitCnt       <= '0;
      seqAddress    <= 1'b0;
      seqWrite      <= 1'b0;
      sampleAddress <= '0;
      sampleRead    <= 1'b0;
      sampleWrite   <= 1'b0;
      adcWriteData  <= '0;
      scanDone      <= 1'b0;
      scanCount     <= '0;
      timeoutErr    <= 1'b0;
      // NOTE: the result file is reset because the CPU may read it before the
      // first scan; the shadow buffer is not, since every commit is preceded
      // by a full rewrite of it.
      for (int i = 0; i < NUM_SLOTS; i++) resultFile[i] <= '0;
    end else begin
      seqWrite    <= 1'b0;
      sampleWrite <= 1'b0;
      sampleRead  <= 1'b0;
      scanDone    <= 1'b0;
      // A set later in this block overrides the clear (last assignment wins).
      if (clearFlags) timeoutErr <= 1'b0;

      case (state)
        INIT_IER: begin
          sampleWrite   <= 1'b1;
          sampleAddress <= IER_ADDR;
          adcWriteData  <= 32'd1;
          state         <= IDLE;
        end
        IDLE: begin
          if (tick) state <= ARM;
        end
        ARM: begin
          seqWrite     <= 1'b1;
          seqAddress   <= SEQ_CMD;
          adcWriteData <= CMD_RUN_SINGLE;
          waitCnt      <= '0;
          state        <= WAIT_IRQ;
        end
        WAIT_IRQ: begin
          if (sampleIrq) begin
            slot  <= '0;
            state <= RD_REQ;
          end else if (waitCnt == TW'(TIMEOUT_CYCLES - 1)) begin
            timeoutErr <= 1'b1;
            state      <= STOP;
          end else begin
            waitCnt <= waitCnt + TW'(1);
          end
        end
        RD_REQ: begin
          sampleRead    <= 1'b1;
          sampleAddress <= 7'(slot);
          state         <= RD_WAIT;
        end
        RD_WAIT: begin
          if (sampleValid) begin
            if (slot == SW'(NUM_SLOTS - 1)) begin
              state <= CLR_ISR;
            end else begin
              slot  <= slot + SW'(1);
              state <= RD_REQ;
            end
          end
        end
        CLR_ISR: begin
          sampleWrite   <= 1'b1;
          sampleAddress <= ISR_ADDR;
          adcWriteData  <= 32'd1;
          state         <= COMMIT;
        end
        COMMIT: begin
          // Whole-scan copy in one edge: the CPU never sees a mixed scan.
          resultFile <= shadow;
          scanDone   <= 1'b1;
          scanCount  <= scanCount + 16'd1;
          state      <= IDLE;
        end
        STOP: begin
          seqWrite     <= 1'b1;
          seqAddress   <= SEQ_CMD;
          adcWriteData <= CMD_STOP;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == RD_WAIT && sampleValid) shadow[slot] <= sampleDataIn[11:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (overrunSet) begin
      overrun <= 1'b1;
    end else if (clearFlags) begin
      overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resultData <= '0;
    end else if (int'(resultAddr) < NUM_SLOTS) begin
      resultData <= resultFile[resultAddr[SW-1:0]];
    end else begin
      resultData <= '0;
    end
  end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adc_scan_ctrl
// Self-checking bench: an ADC wrapper model answers the controller's CSR
// traffic at the negative edge, and a scan-level reference (values served per
// scan, expected commit count, expected result file) checks the outputs.
// -----------------------------------------------------------------------------
module tb_adc_scan_ctrl;

  localparam int NS      = 8;
  localparam int TMO     = 100;
  localparam int PW      = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [PW-1:0] periodTicks;
  logic          seqAddress, seqRead, seqWrite;
  logic [6:0]    sampleAddress;
  logic          sampleRead, sampleWrite;
  logic [31:0]   adcWriteData;
  logic [31:0]   sampleDataIn;
  logic          sampleValid;
  logic          sampleIrq;
  logic [5:0]    resultAddr;
  logic [11:0]   resultData;
  logic          scanDone;
  logic [15:0]   scanCount;
  logic          overrun, timeoutErr;
  logic          clearFlags;

  adc_scan_ctrl #(
    .NUM_SLOTS      (NS),
    .TIMEOUT_CYCLES (TMO),
    .PERIOD_W       (PW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .periodTicks   (periodTicks),
    .seqAddress    (seqAddress),
    .seqRead       (seqRead),
    .seqWrite      (seqWrite),
    .sampleAddress (sampleAddress),
    .sampleRead    (sampleRead),
    .sampleWrite   (sampleWrite),
    .adcWriteData  (adcWriteData),
    .sampleDataIn  (sampleDataIn),
    .sampleValid   (sampleValid),
    .sampleIrq     (sampleIrq),
    .resultAddr    (resultAddr),
    .resultData    (resultData),
    .scanDone      (scanDone),
    .scanCount     (scanCount),
    .overrun       (overrun),
    .timeoutErr    (timeoutErr),
    .clearFlags    (clearFlags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // ADC wrapper model + scan-level reference
  // ---------------------------------------------------------------------------
  typedef struct {
    int kind;   // 0 = sequencer write, 1 = sample write, 2 = sample read
    int addr;
    int data;
    int when;
  } txn_t;

  txn_t        txLog[$];
  logic [31:0] slotMem  [64];
  logic [11:0] scanVals [NS];
  logic [11:0] expResults [NS];
  int          expCount = 0;
  int          doneCount = 0;
  int          armCount = 0;
  int          stopCount = 0;
  int          lastArmCyc = 0;
  int          lastIsrCyc = 0;
  int          prevDoneCyc = -1;
  int          irqCnt = -1;
  logic        vPipe [2];
  logic [31:0] dPipe [2];

  // Per-phase configuration written by the stimulus process
  bit          irqOn = 1'b1;
  bit          randVals = 1'b0;
  bit          randDelay = 1'b0;
  int          irqDelay = 50;
  bit          b2bCheck = 1'b0;
  int          watchAddr = -1;
  bit          watchHit = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      txLog.delete();
      sampleIrq    = 1'b0;
      sampleValid  = 1'b0;
      sampleDataIn = '0;
      vPipe[0] = 1'b0; vPipe[1] = 1'b0;
      dPipe[0] = '0;   dPipe[1] = '0;
      irqCnt   = -1;
      expCount = 0;
      prevDoneCyc = -1;
      for (int i = 0; i < NS; i++) expResults[i] = '0;
    end else begin
      int nStrobe;
      nStrobe = int'(seqWrite) + int'(sampleWrite) + int'(sampleRead);
      if (nStrobe != 0) begin
        check("one_strobe", nStrobe, 1);
        check("seq_read_tied", seqRead, 0);
      end

      // Read data returns two cycles after the read strobe.
      sampleValid  = vPipe[1];
      sampleDataIn = dPipe[1];
      vPipe[1] = vPipe[0];
      dPipe[1] = dPipe[0];
      vPipe[0] = sampleRead;
      dPipe[0] = sampleRead ? slotMem[sampleAddress[5:0]] : 32'h0;

      if (irqCnt > 0) begin
        irqCnt--;
        if (irqCnt == 0) begin
          sampleIrq = 1'b1;
          irqCnt    = -1;
        end
      end

      if (seqWrite) begin
        txLog.push_back('{0, int'(seqAddress), int'(adcWriteData), cyc});
        if (adcWriteData == 32'h3) begin
          armCount++;
          lastArmCyc = cyc;
          for (int i = 0; i < 64; i++)
            slotMem[i] = randVals ? $urandom : 32'h100 + 32'(i);
          for (int i = 0; i < NS; i++) scanVals[i] = slotMem[i][11:0];
          if (irqOn) irqCnt = randDelay ? int'($urandom_range(30, 5)) : irqDelay;
        end else if (adcWriteData == 32'h0) begin
          stopCount++;
        end
      end
      if (sampleWrite) begin
        txLog.push_back('{1, int'(sampleAddress), int'(adcWriteData), cyc});
        if (sampleAddress == 7'd65 && adcWriteData == 32'd1) begin
          sampleIrq  = 1'b0;
          lastIsrCyc = cyc;
        end
      end
      if (sampleRead) begin
        txLog.push_back('{2, int'(sampleAddress), 0, cyc});
        if (int'(sampleAddress) == watchAddr) watchHit = 1'b1;
      end

      if (scanDone) begin
        doneCount++;
        expCount++;
        for (int i = 0; i < NS; i++) expResults[i] = scanVals[i];
        check("scan_count", scanCount, 32'(expCount & 16'hFFFF));
        // Back-to-back: the scan plus the COMMIT and IDLE cycles.
        if (b2bCheck && prevDoneCyc >= 0)
          check("b2b_gap", cyc - prevDoneCyc, (lastIsrCyc - lastArmCyc + 1) + 2);
        prevDoneCyc = cyc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic waitDone(input int target, input int budget, input string tag);
    int n = 0;
    while (doneCount < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(doneCount >= target), 1);
  endtask

  task automatic waitWatch(input int budget, input string tag);
    int n = 0;
    while (!watchHit && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(watchHit), 1);
  endtask

  task automatic readAll(input string tag);
    for (int i = 0; i < NS; i++) begin
      @(negedge clk);
      resultAddr = 6'(i);
      @(negedge clk);
      check($sformatf("%s_r%0d", tag, i), resultData, expResults[i]);
    end
  endtask

  task automatic pulseClear();
    @(negedge clk);
    clearFlags = 1'b1;
    @(negedge clk);
    clearFlags = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int startDone, startArm, startStop, riseCyc, n;
    logic [11:0] v;

    reset = 1'b1; enable = 1'b0; periodTicks = '0;
    clearFlags = 1'b0; resultAddr = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_seqWrite",    seqWrite, 0);
    check("rst_sampleWrite", sampleWrite, 0);
    check("rst_sampleRead",  sampleRead, 0);
    check("rst_scanCount",   scanCount, 0);
    check("rst_flags",       {overrun, timeoutErr, scanDone}, 0);
    check("rst_resultData",  resultData, 0);
    @(negedge clk);
    reset = 1'b0;

    // --- Phase 1: single periodic scan, fixed slot values ---------------------
    repeat (4) @(negedge clk);
    check("ier_first_kind", txLog.size() > 0 ? txLog[0].kind : -1, 1);
    check("ier_first_addr", txLog.size() > 0 ? txLog[0].addr : -1, 64);
    check("ier_first_data", txLog.size() > 0 ? txLog[0].data : -1, 1);
    irqOn = 1'b1; randVals = 1'b0; randDelay = 1'b0; irqDelay = 50;
    periodTicks = 24'd1000;
    enable = 1'b1;
    waitDone(1, 1400, "p1_scan_done");
    enable = 1'b0;
    repeat (20) @(negedge clk);
    check("p1_done_once", doneCount, 1);
    check("p1_scanCount", scanCount, 1);
    check("p1_log_len", txLog.size(), 11);
    if (txLog.size() >= 11) begin
      check("p1_arm_kind", txLog[1].kind, 0);
      check("p1_arm_data", txLog[1].data, 3);
      for (int i = 0; i < NS; i++) begin
        check($sformatf("p1_rd%0d_kind", i), txLog[2+i].kind, 2);
        check($sformatf("p1_rd%0d_addr", i), txLog[2+i].addr, i);
      end
      check("p1_isr_addr", txLog[10].addr, 65);
      check("p1_isr_data", txLog[10].data, 1);
    end
    @(negedge clk);
    resultAddr = 6'd3;
    @(negedge clk);
    check("p1_result3", resultData, 12'h103);
    readAll("p1");
    check("p1_overrun", overrun, 0);

    // --- Phase 2: back-to-back scans, random data and IRQ latency ------------
    randVals = 1'b1; randDelay = 1'b1;
    periodTicks = '0;
    b2bCheck = 1'b1;
    prevDoneCyc = -1;
    startDone = doneCount;
    enable = 1'b1;
    waitDone(startDone + 5, 3000, "p2_scans");
    enable = 1'b0;
    b2bCheck = 1'b0;
    repeat (150) @(negedge clk);
    check("p2_overrun", overrun, 0);
    readAll("p2");

    // --- Phase 3: period shorter than a scan -> overrun ----------------------
    randDelay = 1'b0; irqDelay = 30;
    periodTicks = 24'd20;
    startDone = doneCount;
    enable = 1'b1;
    waitDone(startDone + 3, 1500, "p3_scans");
    check("p3_overrun_set", overrun, 1);
    enable = 1'b0;
    repeat (150) @(negedge clk);
    check("p3_overrun_sticky", overrun, 1);
    pulseClear();
    check("p3_overrun_clr", overrun, 0);
    check("p3_scanCount", scanCount, 32'(expCount & 16'hFFFF));
    readAll("p3");

    // --- Phase 4: IRQ never arrives -> timeout -------------------------------
    irqOn = 1'b0;
    periodTicks = 24'd10;
    startDone = doneCount;
    startStop = stopCount;
    enable = 1'b1;
    n = 0;
    while (!timeoutErr && n < 400) begin
      @(negedge clk);
      n++;
    end
    riseCyc = cyc;
    enable = 1'b0;
    check("p4_timeout_set", timeoutErr, 1);
    check("p4_timeout_window",
          32'((riseCyc - lastArmCyc) >= TMO && (riseCyc - lastArmCyc) <= TMO + 2), 1);
    repeat (10) @(negedge clk);
    check("p4_stop_write", stopCount - startStop, 1);
    check("p4_no_commit", doneCount - startDone, 0);
    check("p4_scanCount", scanCount, 32'(expCount & 16'hFFFF));
    readAll("p4");
    pulseClear();
    check("p4_flags_clr", {overrun, timeoutErr}, 0);
    irqOn = 1'b1;

    // --- Phase 5: enable dropped while waiting on slot 4 ---------------------
    randDelay = 1'b1;
    periodTicks = 24'd5;
    watchHit = 1'b0;
    watchAddr = 4;
    startDone = doneCount;
    enable = 1'b1;
    waitWatch(300, "p5_slot4_seen");
    enable = 1'b0;
    watchAddr = -1;
    waitDone(startDone + 1, 200, "p5_scan_finishes");
    startArm = armCount;
    repeat (200) @(negedge clk);
    check("p5_no_new_arm", armCount - startArm, 0);
    check("p5_done_count", doneCount - startDone, 1);
    readAll("p5");

    // --- Phase 6: reset while waiting on slot 2 ------------------------------
    periodTicks = '0;
    watchHit = 1'b0;
    watchAddr = 2;
    enable = 1'b1;
    waitWatch(300, "p6_slot2_seen");
    watchAddr = -1;
    #1 reset = 1'b1;
    #1;
    check("p6_rst_strobes", {seqWrite, sampleWrite, sampleRead, scanDone}, 0);
    check("p6_rst_addr", sampleAddress, 0);
    check("p6_rst_data", adcWriteData, 0);
    check("p6_rst_count", scanCount, 0);
    check("p6_rst_result", resultData, 0);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    check("p6_first_kind", txLog.size() > 0 ? txLog[0].kind : -1, 1);
    check("p6_first_addr", txLog.size() > 0 ? txLog[0].addr : -1, 64);
    check("p6_log_len", txLog.size(), 1);
    readAll("p6");
    v = resultData;
    check("p6_result_zero", v, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
